apple1_bus_fabric: RTL and testbench
====================================

Name: apple1_bus_fabric

Overview:
- Parametrised CPU-side bus fabric for the 6502 system.
- Replaces the hard-wired chip-select decode and the fixed-priority read mux with a table-driven decoder.
- Adds per-region wait states, a ready/stall handshake to the CPU, single-shot slave strobes and unmapped-access error flagging.
- Sits between the 6502 core and the RAM, ROM and peripheral slaves.

Parameters:
- NUM_SLAVES, 8: number of decoded regions/slaves (1..16).
- ADDR_W, 16: CPU address width.
- DATA_W, 8: data width.
- SLAVE_BASE, {NUM_SLAVES*ADDR_W}'0: packed base addresses; slave k occupies bits [k*ADDR_W +: ADDR_W].
- SLAVE_MASK, {NUM_SLAVES*ADDR_W}'0: packed compare masks. Hit when (ab & mask) == (base & mask).
- SLAVE_WAIT, {NUM_SLAVES*4}'0: packed 4-bit wait-enable counts per slave. Value 4'hF is reserved for ack mode.
- DEFAULT_DATA, 8'hFF: read data returned for an unmapped address.
- ACK_TIMEOUT, 255: maximum enables to wait for an ack (BUS_ACK_EN only).

Ports:
- clk25 input 1: master clock.
- rst_n input 1: synchronous active-low reset.
- cpu_clken input 1: CPU clock enable.
- ab input ADDR_W: CPU address.
- dbo input DATA_W: CPU write data.
- we input 1: CPU write.
- dbi output DATA_W: CPU read data.
- ready output 1: CPU ready; drive to the 6502 ready pin.
- s_sel output NUM_SLAVES: one-hot decoded select, combinational.
- s_en output NUM_SLAVES: access-complete strobe, one clk25 cycle.
- s_we output NUM_SLAVES: write strobe, equal to s_en & we.
- s_wdata output DATA_W: equal to dbo.
- s_rdata input NUM_SLAVES*DATA_W: packed slave read data.
- s_ack input NUM_SLAVES: slave acknowledge; present only with BUS_ACK_EN.
- bus_err output 1: sticky unmapped-access/timeout flag.
- miss_count output 8: count of unmapped accesses, saturating.

Behaviour:
- Clock and reset: one clock, clk25. Reset rst_n is synchronous and active-low.
- Decode:
  - Hit vector: hit[k] = ((ab & MASK_k) == (BASE_k & MASK_k)).
  - s_sel = lowest-index set bit of hit, so lower index has higher priority.
  - miss when hit == 0.
- FSM states IDLE, WAIT, ACK (ACK exists only with BUS_ACK_EN). Register cnt is 8 bits.
- IDLE:
  - stall = 0 when the selected slave has W = SLAVE_WAIT = 0, or on a miss.
  - When cpu_clken and W > 0: stall = 1 that cycle, load cnt = W-1, go to WAIT.
- WAIT, evaluated on each cpu_clken:
  - cnt == 0: stall = 0 and go to IDLE.
  - Otherwise: cnt decrements and stall = 1.
  - Between enables, the state holds.
- ready = cpu_clken & ~stall.
- s_en[k] = s_sel[k] & ready.
  - Exactly one strobe per access regardless of wait count, so a write never fires twice.
  - A W-wait access therefore completes on enable W+1.
- dbi:
  - Combinational mux of s_rdata for the selected slave.
  - DEFAULT_DATA on a miss.
  - No added latency; slaves must present data by the completing enable.
- Miss handling:
  - Any miss with ready asserts bus_err = 1 (sticky) and increments miss_count, saturating at 255.
- Address stability: the CPU holds ab/we while ready = 0. If ab changes in WAIT, the fabric still completes on the original countdown; behaviour is undefined for the changed address.
- Reset (rst_n = 0 at posedge):
  - state = IDLE, cnt = 0, bus_err = 0, miss_count = 0.
  - While rst_n = 0, stall is forced to 0, so ready = cpu_clken and s_en = 0.
  - A reset asserted mid-WAIT abandons the access with no strobe.
- Simultaneous events: a miss and a wait-state hit cannot coincide (a hit excludes a miss). Overlapping regions resolve by priority only.

Optional Feature:
- Macro BUS_ACK_EN.
- Defined:
  - A slave with SLAVE_WAIT = 4'hF uses ack mode. IDLE goes to ACK with cnt = 0, stall = 1.
  - In ACK, on each cpu_clken:
    - s_ack[k] = 1: complete (stall = 0), go to IDLE.
    - Otherwise, when cnt == ACK_TIMEOUT: complete with dbi = DEFAULT_DATA, assert bus_err, go to IDLE.
    - Otherwise: cnt increments.
- Undefined:
  - There is no s_ack port.
  - 4'hF is treated as a plain 15-enable wait.

Decomposition:
- Header apple1_bus_defs.vh holds:
  - State encodings ST_IDLE/ST_WAIT/ST_ACK.
  - WAIT_W = 4.
  - WAIT_ACK = 4'hF.
  - Macro helpers for packing base/mask/wait tables.
- Sub-module apple1_addr_match: one per slave via generate, taking base/mask/ab and returning hit. The priority encoder stays in the parent.

Test Plan:
- Map RAM 0x0000/mask 0xE000 (W=0), ROM 0xFF00/mask 0xFF00 (W=0). Read 0xFF00 with s_rdata ROM = 0xD8 -> dbi = 0xD8, ready = cpu_clken, s_en[1] pulses once.
- Slave 2 with W=2. Write 0x55 on enable -> ready low for 2 enables, one s_we[2] pulse on the 3rd enable with s_wdata = 0x55.
- Read unmapped 0x9000 -> dbi = 0xFF, bus_err = 1, miss_count = 1. Repeat 300 times -> miss_count = 255.
- Overlapping regions: slave 0 = 0xD010/mask 0xFFFE, slave 3 = 0xD000/mask 0xF000, access 0xD011 -> only s_sel[0].
- Reset asserted during WAIT (cnt = 1) -> next cycle state IDLE, no s_en, bus_err = 0, ready = cpu_clken.
- BUS_ACK_EN with ACK_TIMEOUT = 4:
  - s_ack after 2 enables -> completes on the 3rd.
  - No ack -> completes after 5 enables with dbi = 0xFF, bus_err = 1.

Source files
------------

// File: rtl/apple1_bus_fabric_pkg.sv
// +--------------------------------------------------------------------------+
// | Module      : apple1_bus_fabric_pkg                                      |
// | Description : Shared definitions for the 6502 CPU-side bus fabric:       |
// |               FSM state encodings, wait-table field width and the        |
// |               reserved ack-mode wait code.                               |
// |               Also provides table-packing helpers for building the       |
// |               base/mask/wait parameter tables.                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

package apple1_bus_fabric_pkg;

  // Width of one entry in the packed per-slave wait table.
  localparam int WAIT_W = 4;

  // Wait code reserved for ack mode (only meaningful with BUS_ACK_EN).
  localparam logic [WAIT_W-1:0] WAIT_ACK = 4'hF;

  // Width of the shared wait/ack counter.
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } bus_state_e;

  // Table-packing helpers for building SLAVE_BASE / SLAVE_MASK / SLAVE_WAIT.
  // Slot k occupies bits [k*width +: width] of the packed table.
  // Both helpers return the table with that slot replaced, so an
  // integrator can build a table one slave at a time from '0.
  function automatic logic [255:0] pack_addr(input logic [255:0] tbl, input int slot,
                                             input int addr_w, input logic [15:0] value);
    logic [255:0] t;
    t = tbl;
    for (int b = 0; b < addr_w; b++) begin
      t[slot*addr_w + b] = value[b];
    end
    return t;
  endfunction

  function automatic logic [63:0] pack_wait(input logic [63:0] tbl, input int slot,
                                            input logic [WAIT_W-1:0] value);
    logic [63:0] t;
    t = tbl;
    t[slot*WAIT_W +: WAIT_W] = value;
    return t;
  endfunction

endpackage

`default_nettype wire

// File: rtl/apple1_addr_match.sv
// +--------------------------------------------------------------------------+
// | Module      : apple1_addr_match                                          |
// | Description : Single-region address comparator. Reports a hit when the   |
// |               masked CPU address equals the masked region base.          |
// | Ports       : base_i  - region base address                              |
// |               mask_i  - compare mask (1 = bit participates)              |
// |               ab_i    - CPU address                                      |
// |               hit_o   - region hit                                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module apple1_addr_match #(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] mask_i,
  input  logic [ADDR_W-1:0] ab_i,
  output logic              hit_o
);

  assign hit_o = ((ab_i & mask_i) == (base_i & mask_i));

endmodule

`default_nettype wire

// File: rtl/apple1_bus_fabric.sv
// +--------------------------------------------------------------------------+
// | Module      : apple1_bus_fabric                                          |
// | Description : Table-driven CPU-side bus fabric for the 6502 system.      |
// |               Decodes the CPU address against NUM_SLAVES regions         |
// |               (lowest index wins), inserts per-region wait states via    |
// |               the 6502 ready pin, issues one access-complete strobe per  |
// |               access and flags unmapped accesses.                        |
// | Option      : BUS_ACK_EN - enables ack mode (wait code 4'hF) with the    |
// |               s_ack input and an ACK_TIMEOUT-enable timeout.             |
// | Ports       : clk25, rst_n (sync, active-low), cpu_clken               |
// |               ab/dbo/we  - CPU address, write data, write              |
// |               dbi/ready  - CPU read data, CPU ready                     |
// |               s_sel/s_en/s_we/s_wdata - slave select, strobe, wr data  |
// |               s_rdata    - packed slave read data                       |
// |               s_ack      - slave acknowledge (BUS_ACK_EN only)          |
// |               bus_err    - sticky error, miss_count - saturating misses |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module apple1_bus_fabric
  import apple1_bus_fabric_pkg::*;
#(
  parameter int                            NUM_SLAVES   = 8,
  parameter int                            ADDR_W       = 16,
  parameter int                            DATA_W       = 8,
  parameter logic [NUM_SLAVES*ADDR_W-1:0]  SLAVE_BASE   = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0]  SLAVE_MASK   = '0,
  parameter logic [NUM_SLAVES*WAIT_W-1:0]  SLAVE_WAIT   = '0,
  parameter logic [DATA_W-1:0]             DEFAULT_DATA = 8'hFF,
  parameter int                            ACK_TIMEOUT  = 255
) (
  input  logic                         clk25,
  input  logic                         rst_n,
  input  logic                         cpu_clken,
  input  logic [ADDR_W-1:0]            ab,
  input  logic [DATA_W-1:0]            dbo,
  input  logic                         we,
  output logic [DATA_W-1:0]            dbi,
  output logic                         ready,
  output logic [NUM_SLAVES-1:0]        s_sel,
  output logic [NUM_SLAVES-1:0]        s_en,
  output logic [NUM_SLAVES-1:0]        s_we,
  output logic [DATA_W-1:0]            s_wdata,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
`ifdef BUS_ACK_EN
  input  logic [NUM_SLAVES-1:0]        s_ack,
`endif
  output logic                         bus_err,
  output logic [7:0]                   miss_count
);

  bus_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   bus_err_q;
  logic [7:0]             miss_count_q;

  logic [NUM_SLAVES-1:0]  hit;
  logic [NUM_SLAVES-1:0]  sel;
  logic                   miss;
  logic [DATA_W-1:0]      rdata_sel;
  logic [WAIT_W-1:0]      wait_sel;
  logic                   stall;
  logic                   timeout;

  // ---------------------------------------------------------------------------
  // Region comparators
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_SLAVES; k++) begin : g_match
    apple1_addr_match #(
      .ADDR_W (ADDR_W)
    ) u_match (
      .base_i (SLAVE_BASE[k*ADDR_W +: ADDR_W]),
      .mask_i (SLAVE_MASK[k*ADDR_W +: ADDR_W]),
      .ab_i   (ab),
      .hit_o  (hit[k])
    );
  end

  // Priority encoder: scanning from the top down lets the lowest set index
  // overwrite any higher one, so overlapping regions resolve to the lowest.
  always_comb begin
    sel = '0;
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      if (hit[k]) begin
        sel    = '0;
        sel[k] = 1'b1;
      end
    end
  end

  assign miss = (hit == '0);

  // One-hot select steers read data and the wait code of the selected slave.
  always_comb begin
    rdata_sel = '0;
    wait_sel  = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (sel[k]) begin
        rdata_sel = s_rdata[k*DATA_W +: DATA_W];
        wait_sel  = SLAVE_WAIT[k*WAIT_W +: WAIT_W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Wait-state / ack FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    timeout = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!miss && (wait_sel != '0)) begin
          stall = 1'b1;
          if (cpu_clken) begin
            // First enable of a waited access counts as one of the W stalls.
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(wait_sel) - CNT_W'(1);
`ifdef BUS_ACK_EN
            if (wait_sel == WAIT_ACK) begin
              state_d = ST_ACK;
              cnt_d   = '0;
            end
`endif
          end
        end
      end
      ST_WAIT: begin
        stall = 1'b1;
        if (cpu_clken) begin
          if (cnt_q == '0) begin
            stall   = 1'b0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
`ifdef BUS_ACK_EN
      ST_ACK: begin
        stall = 1'b1;
        if (cpu_clken) begin
          if ((s_ack & sel) != '0) begin
            stall   = 1'b0;
            state_d = ST_IDLE;
          end else if (cnt_q == CNT_W'(ACK_TIMEOUT)) begin
            // Give up: complete the access with default data and flag it.
            stall   = 1'b0;
            timeout = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // While held in reset the CPU must run freely.
    if (!rst_n) begin
      stall = 1'b0;
    end
  end

`ifndef BUS_ACK_EN
  // Timeout only applies to ack mode; keep the parameter visibly consumed.
  logic [CNT_W-1:0] unused_ack_timeout;
  assign unused_ack_timeout = CNT_W'(ACK_TIMEOUT);
`endif

  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bus_err_q    <= 1'b0;
      miss_count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (ready && (miss || timeout)) begin
        bus_err_q <= 1'b1;
      end
      if (ready && miss && (miss_count_q != 8'hFF)) begin
        miss_count_q <= miss_count_q + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ready      = cpu_clken & ~stall;
  // Strobe only on the completing enable, and never while in reset.
  assign s_en       = sel & {NUM_SLAVES{ready & rst_n}};
  assign s_we       = s_en & {NUM_SLAVES{we}};
  assign s_sel      = sel;
  assign s_wdata    = dbo;
  assign dbi        = (miss || timeout) ? DEFAULT_DATA : rdata_sel;
  assign bus_err    = bus_err_q;
  assign miss_count = miss_count_q;

endmodule

`default_nettype wire

// File: tb/tb_apple1_bus_fabric.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_apple1_bus_fabric                                       |
// | Description : Directed self-checking bench for apple1_bus_fabric.        |
// |               Map: s0 D010/FFFE W0, s1 FF00/FF00 W0 (ROM),              |
// |               s2 C000/FF00 W2, s3 D000/F000 W0, s4 0000/E000 W0 (RAM),  |
// |               s5 E000/FF00 W=F (ack mode with BUS_ACK_EN),              |
// |               s6 A000/FF00, s7 B000/FF00.                               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_apple1_bus_fabric;

  localparam logic [127:0] TB_BASE = {16'hB000, 16'hA000, 16'hE000, 16'h0000,
                                      16'hD000, 16'hC000, 16'hFF00, 16'hD010};
  localparam logic [127:0] TB_MASK = {16'hFF00, 16'hFF00, 16'hFF00, 16'hE000,
                                      16'hF000, 16'hFF00, 16'hFF00, 16'hFFFE};
  localparam logic [31:0]  TB_WAIT = {4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0};

  localparam logic [15:0] OV_ADDR [5] = '{16'hD011, 16'hD010, 16'hD020, 16'h1234, 16'hC0FF};
  localparam logic [7:0]  OV_SEL  [5] = '{8'h01, 8'h01, 8'h08, 8'h10, 8'h04};
  localparam logic [7:0]  OV_DBI  [5] = '{8'h10, 8'h10, 8'h13, 8'h14, 8'h12};

  logic        clk25;
  logic        rst_n;
  logic        cpu_clken;
  logic [15:0] ab;
  logic [7:0]  dbo;
  logic        we;
  logic [7:0]  dbi;
  logic        ready;
  logic [7:0]  s_sel;
  logic [7:0]  s_en;
  logic [7:0]  s_we;
  logic [7:0]  s_wdata;
  logic [63:0] s_rdata;
`ifdef BUS_ACK_EN
  logic [7:0]  s_ack;
`endif
  logic        bus_err;
  logic [7:0]  miss_count;

  int checks;
  int failures;

  apple1_bus_fabric #(
    .NUM_SLAVES   (8),
    .ADDR_W       (16),
    .DATA_W       (8),
    .SLAVE_BASE   (TB_BASE),
    .SLAVE_MASK   (TB_MASK),
    .SLAVE_WAIT   (TB_WAIT),
    .DEFAULT_DATA (8'hFF),
    .ACK_TIMEOUT  (4)
  ) dut (
    .clk25      (clk25),
    .rst_n      (rst_n),
    .cpu_clken  (cpu_clken),
    .ab         (ab),
    .dbo        (dbo),
    .we         (we),
    .dbi        (dbi),
    .ready      (ready),
    .s_sel      (s_sel),
    .s_en       (s_en),
    .s_we       (s_we),
    .s_wdata    (s_wdata),
    .s_rdata    (s_rdata),
`ifdef BUS_ACK_EN
    .s_ack      (s_ack),
`endif
    .bus_err    (bus_err),
    .miss_count (miss_count)
  );

  initial clk25 = 1'b0;
  always #5 clk25 = ~clk25;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk25);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cpu_clken = 1'b0; ab = 16'hFF00; we = 1'b0; dbo = 8'h00;
    s_rdata = {8'h17, 8'h16, 8'h15, 8'h14, 8'h13, 8'h12, 8'hD8, 8'h10};
`ifdef BUS_ACK_EN
    s_ack = 8'h00;
`endif
    tick(); tick();
    checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL reset_bus_err got=%b exp=0", bus_err); end
    checks++; if (miss_count !== 8'h00) begin failures++; $display("FAIL reset_miss_count got=%h exp=00", miss_count); end
    cpu_clken = 1'b1; #1;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
    checks++; if (s_en !== 8'h00) begin failures++; $display("FAIL reset_s_en got=%h exp=00", s_en); end
    tick();
    rst_n = 1'b1; cpu_clken = 1'b0;
    tick();
  endtask

  task automatic test_rom_read();
    ab = 16'hFF00; we = 1'b0; cpu_clken = 1'b0; #1;
    checks++; if (s_sel !== 8'h02) begin failures++; $display("FAIL rom_sel got=%h exp=02", s_sel); end
    checks++; if (dbi !== 8'hD8) begin failures++; $display("FAIL rom_dbi got=%h exp=d8", dbi); end
    checks++; if (ready !== 1'b0 || s_en !== 8'h00) begin failures++; $display("FAIL rom_idle got ready=%b s_en=%h exp 0/00", ready, s_en); end
    cpu_clken = 1'b1; #1;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL rom_ready got=%b exp=1", ready); end
    checks++; if (s_en !== 8'h02 || s_we !== 8'h00) begin failures++; $display("FAIL rom_strobe got s_en=%h s_we=%h exp 02/00", s_en, s_we); end
    tick();
    cpu_clken = 1'b0; #1;
    checks++; if (s_en !== 8'h00) begin failures++; $display("FAIL rom_strobe_end got=%h exp=00", s_en); end
    checks++; if (bus_err !== 1'b0 || miss_count !== 8'h00) begin failures++; $display("FAIL rom_no_err got err=%b cnt=%h exp 0/00", bus_err, miss_count); end
    tick();
  endtask

  task automatic test_wait_write();
    int pulses;
    pulses = 0;
    ab = 16'hC000; we = 1'b1; dbo = 8'h55;
    for (int e = 1; e <= 3; e++) begin
      cpu_clken = 1'b1; #1;
      checks++; if (ready !== (e == 3)) begin failures++; $display("FAIL wait_ready enable=%0d got=%b exp=%b", e, ready, (e == 3)); end
      checks++; if (s_we !== ((e == 3) ? 8'h04 : 8'h00)) begin failures++; $display("FAIL wait_s_we enable=%0d got=%h", e, s_we); end
      if (s_we[2]) pulses++;
      tick();
      cpu_clken = 1'b0; #1;
      checks++; if (ready !== 1'b0 || s_en !== 8'h00) begin failures++; $display("FAIL wait_gap enable=%0d got ready=%b s_en=%h exp 0/00", e, ready, s_en); end
      if (s_we[2]) pulses++;
      tick();
    end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL wait_pulses got=%0d exp=1", pulses); end
    checks++; if (s_wdata !== 8'h55) begin failures++; $display("FAIL wait_wdata got=%h exp=55", s_wdata); end
    we = 1'b0;
  endtask

  task automatic test_overlap();
    cpu_clken = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ab = OV_ADDR[i]; #1;
      checks++; if (s_sel !== OV_SEL[i]) begin failures++; $display("FAIL overlap_sel addr=%h got=%h exp=%h", ab, s_sel, OV_SEL[i]); end
      checks++; if (dbi !== OV_DBI[i]) begin failures++; $display("FAIL overlap_dbi addr=%h got=%h exp=%h", ab, dbi, OV_DBI[i]); end
    end
    tick();
  endtask

  task automatic test_miss();
    ab = 16'h9000; we = 1'b0; cpu_clken = 1'b1; #1;
    checks++; if (dbi !== 8'hFF) begin failures++; $display("FAIL miss_dbi got=%h exp=ff", dbi); end
    checks++; if (s_sel !== 8'h00 || s_en !== 8'h00) begin failures++; $display("FAIL miss_sel got sel=%h en=%h exp 00/00", s_sel, s_en); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL miss_ready got=%b exp=1", ready); end
    tick();
    checks++; if (bus_err !== 1'b1) begin failures++; $display("FAIL miss_bus_err got=%b exp=1", bus_err); end
    checks++; if (miss_count !== 8'd1) begin failures++; $display("FAIL miss_count_1 got=%0d exp=1", miss_count); end
    repeat (299) tick();
    checks++; if (miss_count !== 8'd255) begin failures++; $display("FAIL miss_count_sat got=%0d exp=255", miss_count); end
    cpu_clken = 1'b0; ab = 16'h0000;
    tick();
    checks++; if (bus_err !== 1'b1) begin failures++; $display("FAIL miss_sticky got=%b exp=1", bus_err); end
  endtask

  task automatic test_reset_mid_wait();
    ab = 16'hC000; we = 1'b1; dbo = 8'hAA; cpu_clken = 1'b1; #1;
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL rstwait_first got=%b exp=0", ready); end
    tick();
    cpu_clken = 1'b0;
    tick();
    rst_n = 1'b0; cpu_clken = 1'b1; #1;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL rstwait_ready got=%b exp=1", ready); end
    checks++; if (s_en !== 8'h00 || s_we !== 8'h00) begin failures++; $display("FAIL rstwait_strobe got en=%h we=%h exp 00/00", s_en, s_we); end
    tick();
    rst_n = 1'b1; cpu_clken = 1'b0; we = 1'b0; ab = 16'h0000; #1;
    checks++; if (bus_err !== 1'b0 || miss_count !== 8'h00) begin failures++; $display("FAIL rstwait_clear got err=%b cnt=%h exp 0/00", bus_err, miss_count); end
    cpu_clken = 1'b1; #1;
    checks++; if (ready !== 1'b1 || s_en !== 8'h10) begin failures++; $display("FAIL rstwait_idle got ready=%b en=%h exp 1/10", ready, s_en); end
    tick();
    cpu_clken = 1'b0;
    tick();
  endtask

`ifdef BUS_ACK_EN
  task automatic test_ack();
    int done;
    int pulses;
    logic [7:0] got_dbi;
    ab = 16'hE000; we = 1'b0; s_ack = 8'h00;
    for (int e = 1; e <= 2; e++) begin
      cpu_clken = 1'b1; #1;
      checks++; if (ready !== 1'b0) begin failures++; $display("FAIL ack_stall enable=%0d got=%b exp=0", e, ready); end
      tick();
    end
    s_ack = 8'h20; #1;
    checks++; if (ready !== 1'b1 || s_en !== 8'h20) begin failures++; $display("FAIL ack_done got ready=%b en=%h exp 1/20", ready, s_en); end
    checks++; if (dbi !== 8'h15) begin failures++; $display("FAIL ack_dbi got=%h exp=15", dbi); end
    tick();
    s_ack = 8'h00; cpu_clken = 1'b0;
    tick();
    checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL ack_no_err got=%b exp=0", bus_err); end

    done = 0; pulses = 0; got_dbi = 8'h00;
    cpu_clken = 1'b1;
    for (int i = 1; i <= 12 && done == 0; i++) begin
      #1;
      if (s_en[5]) pulses++;
      if (ready) begin done = i; got_dbi = dbi; end
      tick();
    end
    cpu_clken = 1'b0;
    tick();
    checks++; if (done !== 6) begin failures++; $display("FAIL ack_timeout_enable got=%0d exp=6", done); end
    checks++; if (got_dbi !== 8'hFF) begin failures++; $display("FAIL ack_timeout_dbi got=%h exp=ff", got_dbi); end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL ack_timeout_pulses got=%0d exp=1", pulses); end
    checks++; if (bus_err !== 1'b1) begin failures++; $display("FAIL ack_timeout_err got=%b exp=1", bus_err); end
  endtask
`else
  task automatic test_slow_region();
    int done;
    int pulses;
    logic [7:0] got_dbi;
    done = 0; pulses = 0; got_dbi = 8'h00;
    ab = 16'hE000; we = 1'b0; cpu_clken = 1'b1;
    for (int i = 1; i <= 40 && done == 0; i++) begin
      #1;
      if (s_en[5]) pulses++;
      if (ready) begin done = i; got_dbi = dbi; end
      tick();
    end
    cpu_clken = 1'b0;
    tick();
    checks++; if (done !== 16) begin failures++; $display("FAIL slow_enable got=%0d exp=16", done); end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL slow_pulses got=%0d exp=1", pulses); end
    checks++; if (got_dbi !== 8'h15) begin failures++; $display("FAIL slow_dbi got=%h exp=15", got_dbi); end
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_rom_read();
    test_wait_write();
    test_overlap();
    test_miss();
    test_reset_mid_wait();
`ifdef BUS_ACK_EN
    test_ack();
`else
    test_slow_region();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
